// File: rtl/angle_pkg.sv
// Shared types and constants for the best-angle tracker.
//   state_t         : tracker FSM states
//   NO_MATCH_ANGLE  : buffer value meaning "no candidate qualified" (all ones)
//   RDY_CYCLES      : result strobe length the SRAM controller expects
//   *_DEF           : default datapath widths
package angle_pkg;

  localparam int unsigned ANGLE_W_DEF   = 12;
  localparam int unsigned SCORE_W_DEF   = 16;
  localparam int unsigned TAU_W         = 8;
  localparam int unsigned TAU_SHIFT_DEF = 8;
  localparam int unsigned MATCH_CNT_W   = 16;
  localparam int unsigned RDY_CYCLES    = 2;
  localparam int unsigned ANGLE_PAIR_W  = 2 * ANGLE_W_DEF;

  localparam logic [ANGLE_PAIR_W-1:0] NO_MATCH_ANGLE = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [ANGLE_W_DEF-1:0] theta;
    logic [ANGLE_W_DEF-1:0] phi;
  } angle_pair_t;

  // Saturating increment for the match counter.
  function automatic logic [MATCH_CNT_W-1:0] sat_inc(input logic [MATCH_CNT_W-1:0] v);
    return (v == '1) ? v : v + MATCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/best_angle_tracker_score_cmp.sv
// score_cmp: combinational candidate decision.
//   i_score       candidate score (unsigned)
//   i_best_score  current best score
//   i_thresh      qualification threshold
//   i_has_best    a best candidate already exists in this pass
//   o_qualify_c   candidate clears the threshold
//   o_replace_c   candidate becomes the new best (strictly better, ties keep earlier)
module score_cmp #(
  parameter int unsigned SCORE_W = angle_pkg::SCORE_W_DEF
) (
  input  logic [SCORE_W-1:0] i_score,
  input  logic [SCORE_W-1:0] i_best_score,
  input  logic [SCORE_W-1:0] i_thresh,
  input  logic               i_has_best,
  output logic               o_qualify_c,
  output logic               o_replace_c
);

  assign o_qualify_c = (i_score >= i_thresh);
  assign o_replace_c = o_qualify_c && (!i_has_best || (i_score > i_best_score));

endmodule

// File: rtl/best_angle_tracker.sv
// best_angle_tracker: keeps the best above-threshold candidate angle of a
// matching pass and strobes it to the SRAM controller at end of pass.
//   clk, rst                  clock, asynchronous active-low reset
//   i_start, i_tau            begin pass, threshold (tau << TAU_SHIFT)
//   i_cand_*                  candidate stream (valid, theta, phi, score, last)
//   o_best_angle_rdy          result strobe, RDY_CYCLES cycles long
//   o_candidate_angle_buffer  {theta, phi} of the winner (all ones if none)
//   o_no_match                no candidate qualified in the pass
//   o_match_cnt               qualifying candidate count
// Optional feature macro: BEST_ANGLE_MATCH_CNT_EN builds the match counter;
// without it o_match_cnt is tied to zero.
module best_angle_tracker
  import angle_pkg::*;
#(
  parameter int unsigned ANGLE_W   = ANGLE_W_DEF,
  parameter int unsigned SCORE_W   = SCORE_W_DEF,
  parameter int unsigned TAU_SHIFT = TAU_SHIFT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [TAU_W-1:0]       i_tau,
  input  logic                   i_cand_valid,
  input  logic [ANGLE_W-1:0]     i_cand_theta,
  input  logic [ANGLE_W-1:0]     i_cand_phi,
  input  logic [SCORE_W-1:0]     i_cand_score,
  input  logic                   i_cand_last,
  output logic                   o_best_angle_rdy,
  output logic [2*ANGLE_W-1:0]   o_candidate_angle_buffer,
  output logic                   o_no_match,
  output logic [MATCH_CNT_W-1:0] o_match_cnt
);

  localparam int unsigned BUF_W     = 2 * ANGLE_W;
  localparam int unsigned TH_W      = TAU_W + TAU_SHIFT;
  localparam int unsigned RDY_CNT_W = (RDY_CYCLES > 1) ? $clog2(RDY_CYCLES) : 1;
  localparam logic [BUF_W-1:0]     NO_MATCH_BUF = {BUF_W{NO_MATCH_ANGLE[0]}};
  localparam logic [RDY_CNT_W-1:0] RDY_LAST     = RDY_CNT_W'(RDY_CYCLES - 1);

  state_t                 r_state, w_state_nxt;
  logic [RDY_CNT_W-1:0]   r_rdy_cnt, w_rdy_cnt_nxt;
  logic                   r_rdy, w_rdy_nxt;
  logic [BUF_W-1:0]       r_best_angle, w_best_angle_nxt;
  logic [SCORE_W-1:0]     r_best_score, w_best_score_nxt;
  logic [SCORE_W-1:0]     r_thresh, w_thresh_nxt;
  logic                   r_no_match, w_no_match_nxt;

  logic [TH_W-1:0]        w_tau_shifted;
  logic [SCORE_W-1:0]     w_thresh;
  logic                   w_start_acc;
  logic                   w_cand;
  logic                   w_qualify;
  logic                   w_replace;

  // Threshold from the raw tau; saturates if the shift overflows SCORE_W.
  assign w_tau_shifted = TH_W'(i_tau) << TAU_SHIFT;

  generate
    if (TH_W > SCORE_W) begin : g_th_sat
      assign w_thresh = (|w_tau_shifted[TH_W-1:SCORE_W]) ? '1 : w_tau_shifted[SCORE_W-1:0];
    end else begin : g_th_ext
      assign w_thresh = SCORE_W'(w_tau_shifted);
    end
  endgenerate

  // start is ignored while the strobe is running; it preempts any candidate.
  assign w_start_acc = i_start && (r_state != ST_REPORT);
  assign w_cand      = (r_state == ST_SCAN) && i_cand_valid && !i_start;

  // Best exists exactly when no_match has been cleared in this pass.
  score_cmp #(
    .SCORE_W (SCORE_W)
  ) u_score_cmp (
    .i_score      (i_cand_score),
    .i_best_score (r_best_score),
    .i_thresh     (r_thresh),
    .i_has_best   (!r_no_match),
    .o_qualify_c  (w_qualify),
    .o_replace_c  (w_replace)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (i_start)                          w_state_nxt = ST_SCAN;
        else if (i_cand_valid && i_cand_last) w_state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        if (r_rdy_cnt == RDY_LAST) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_rdy_nxt        = 1'b0;
    w_rdy_cnt_nxt    = '0;
    w_best_angle_nxt = r_best_angle;
    w_best_score_nxt = r_best_score;
    w_thresh_nxt     = r_thresh;
    w_no_match_nxt   = r_no_match;

    if (w_start_acc) begin
      w_thresh_nxt     = w_thresh;
      w_best_score_nxt = '0;
      w_best_angle_nxt = NO_MATCH_BUF;
      w_no_match_nxt   = 1'b1;
    end else if (w_cand && w_replace) begin
      w_best_score_nxt = i_cand_score;
      w_best_angle_nxt = {i_cand_theta, i_cand_phi};
      w_no_match_nxt   = 1'b0;
    end

    // Strobe rises with the last candidate so it is high the cycle after.
    if (w_cand && i_cand_last) begin
      w_rdy_nxt = 1'b1;
    end

    if (r_state == ST_REPORT && r_rdy_cnt != RDY_LAST) begin
      w_rdy_nxt     = 1'b1;
      w_rdy_cnt_nxt = r_rdy_cnt + RDY_CNT_W'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_cnt    <= '0;
      r_rdy        <= 1'b0;
      r_best_angle <= NO_MATCH_BUF;
      r_best_score <= '0;
      r_thresh     <= '0;
      r_no_match   <= 1'b1;
    end else begin
      r_rdy_cnt    <= w_rdy_cnt_nxt;
      r_rdy        <= w_rdy_nxt;
      r_best_angle <= w_best_angle_nxt;
      r_best_score <= w_best_score_nxt;
      r_thresh     <= w_thresh_nxt;
      r_no_match   <= w_no_match_nxt;
    end
  end

`ifdef BEST_ANGLE_MATCH_CNT_EN
  logic [MATCH_CNT_W-1:0] r_match_cnt;

  // Saturating count of qualifying candidates in the current pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_match_cnt <= '0;
    end else if (w_start_acc) begin
      r_match_cnt <= '0;
    end else if (w_cand && w_qualify) begin
      r_match_cnt <= sat_inc(r_match_cnt);
    end
  end

  assign o_match_cnt = r_match_cnt;
`else
  logic w_unused_qualify;
  assign w_unused_qualify = w_qualify;
  assign o_match_cnt      = '0;
`endif

  assign o_best_angle_rdy         = r_rdy;
  assign o_candidate_angle_buffer = r_best_angle;
  assign o_no_match               = r_no_match;

endmodule

// File: tb/tb_best_angle_tracker.sv
// Directed bench for best_angle_tracker: table of per-cycle vectors plus
// hand sequences for the match counter and reset during the strobe.
module tb_best_angle_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_tau = '0;
  logic        i_cand_valid = 1'b0;
  logic [11:0] i_cand_theta = '0;
  logic [11:0] i_cand_phi = '0;
  logic [15:0] i_cand_score = '0;
  logic        i_cand_last = 1'b0;
  logic        o_best_angle_rdy;
  logic [23:0] o_candidate_angle_buffer;
  logic        o_no_match;
  logic [15:0] o_match_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        start;
    logic [7:0]  tau;
    logic        valid;
    logic [11:0] theta;
    logic [11:0] phi;
    logic [15:0] score;
    logic        last;
    logic        exp_rdy;
    logic [23:0] exp_buf;
    logic        exp_nm;
    logic [15:0] exp_mc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  best_angle_tracker dut (
    .clk                      (clk),
    .rst                      (rst),
    .i_start                  (i_start),
    .i_tau                    (i_tau),
    .i_cand_valid             (i_cand_valid),
    .i_cand_theta             (i_cand_theta),
    .i_cand_phi               (i_cand_phi),
    .i_cand_score             (i_cand_score),
    .i_cand_last              (i_cand_last),
    .o_best_angle_rdy         (o_best_angle_rdy),
    .o_candidate_angle_buffer (o_candidate_angle_buffer),
    .o_no_match               (o_no_match),
    .o_match_cnt              (o_match_cnt)
  );

  // Expected match count depends on whether the counter is built.
  function automatic logic [15:0] mc(input logic [15:0] on_val);
`ifdef BEST_ANGLE_MATCH_CNT_EN
    return on_val;
`else
    return on_val & 16'h0000;
`endif
  endfunction

  function automatic void add(input logic st, input logic [7:0] tau, input logic v,
                              input logic [11:0] th, input logic [11:0] ph,
                              input logic [15:0] sc, input logic la, input logic e_rdy,
                              input logic [23:0] e_buf, input logic e_nm,
                              input logic [15:0] e_mc);
    vec_t r;
    r.start = st; r.tau = tau; r.valid = v; r.theta = th; r.phi = ph;
    r.score = sc; r.last = la; r.exp_rdy = e_rdy; r.exp_buf = e_buf;
    r.exp_nm = e_nm; r.exp_mc = mc(e_mc);
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic e_rdy, input logic [23:0] e_buf,
                            input logic e_nm, input logic [15:0] e_mc);
    check({tag, "_rdy"}, 32'(o_best_angle_rdy), 32'(e_rdy));
    check({tag, "_buf"}, 32'(o_candidate_angle_buffer), 32'(e_buf));
    check({tag, "_nm"},  32'(o_no_match), 32'(e_nm));
    check({tag, "_mc"},  32'(o_match_cnt), 32'(e_mc));
  endtask

  task automatic drive(input logic st, input logic [7:0] tau, input logic v,
                       input logic [11:0] th, input logic [11:0] ph,
                       input logic [15:0] sc, input logic la);
    i_start = st; i_tau = tau; i_cand_valid = v; i_cand_theta = th;
    i_cand_phi = ph; i_cand_score = sc; i_cand_last = la;
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 1'b0, 12'h0, 12'h0, 16'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic pass: best of 300/500/400 at tau=1 (threshold 256).
    add(1, 8'd1, 0, 12'h000, 12'h000, 16'd0,   0, 0, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 1, 12'h010, 12'h020, 16'd300, 0, 0, 24'h010020, 0, 1);
    add(0, 8'd0, 1, 12'h011, 12'h021, 16'd500, 0, 0, 24'h011021, 0, 2);
    add(0, 8'd0, 1, 12'h012, 12'h022, 16'd400, 1, 1, 24'h011021, 0, 3);
    add(0, 8'd0, 0, 12'h000, 12'h000, 16'd0,   0, 1, 24'h011021, 0, 3);
    add(0, 8'd0, 0, 12'h000, 12'h000, 16'd0,   0, 0, 24'h011021, 0, 3);
    add(0, 8'd0, 1, 12'h777, 12'h777, 16'd9000,1, 0, 24'h011021, 0, 3);
    // Tie keeps the earlier candidate; start during the strobe is ignored.
    add(1, 8'd1, 0, 12'h000, 12'h000, 16'd0,   0, 0, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 1, 12'h001, 12'h002, 16'd500, 0, 0, 24'h001002, 0, 1);
    add(0, 8'd0, 1, 12'h003, 12'h004, 16'd500, 1, 1, 24'h001002, 0, 2);
    add(1, 8'd9, 0, 12'h000, 12'h000, 16'd0,   0, 1, 24'h001002, 0, 2);
    add(0, 8'd0, 0, 12'h000, 12'h000, 16'd0,   0, 0, 24'h001002, 0, 2);
    // Nothing clears tau=4 (1024); tau is latched, not live.
    add(1, 8'd4, 0, 12'h000, 12'h000, 16'd0,   0, 0, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 1, 12'h005, 12'h006, 16'd1000,0, 0, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 1, 12'h007, 12'h008, 16'd1023,1, 1, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 0, 12'h000, 12'h000, 16'd0,   0, 1, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 0, 12'h000, 12'h000, 16'd0,   0, 0, 24'hFFFFFF, 1, 0);
    // Restart mid-scan drops the same-cycle candidate; threshold boundary.
    add(1, 8'd2, 0, 12'h000, 12'h000, 16'd0,   0, 0, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 1, 12'h0AA, 12'h0BB, 16'd900, 0, 0, 24'h0AA0BB, 0, 1);
    add(1, 8'd1, 1, 12'h0CC, 12'h0DD, 16'd950, 1, 0, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 0, 12'h000, 12'h000, 16'd0,   1, 0, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 1, 12'h111, 12'h222, 16'd255, 0, 0, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 1, 12'h333, 12'h444, 16'd256, 0, 0, 24'h333444, 0, 1);
    add(0, 8'd0, 1, 12'h0EE, 12'h0FF, 16'd300, 1, 1, 24'h0EE0FF, 0, 2);
    add(0, 8'd0, 0, 12'h000, 12'h000, 16'd0,   0, 1, 24'h0EE0FF, 0, 2);
    add(0, 8'd0, 0, 12'h000, 12'h000, 16'd0,   0, 0, 24'h0EE0FF, 0, 2);
    // Largest tau: threshold 0xFF00.
    add(1, 8'hFF,0, 12'h000, 12'h000, 16'd0,   0, 0, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 1, 12'h123, 12'h456, 16'hFEFF,0, 0, 24'hFFFFFF, 1, 0);
    add(0, 8'd0, 1, 12'h789, 12'hABC, 16'hFF00,1, 1, 24'h789ABC, 0, 1);
    add(0, 8'd0, 0, 12'h000, 12'h000, 16'd0,   0, 1, 24'h789ABC, 0, 1);
    add(0, 8'd0, 0, 12'h000, 12'h000, 16'd0,   0, 0, 24'h789ABC, 0, 1);

    // Reset values while reset is held.
    #2 rst = 1'b0;
    step();
    check_outs("reset", 1'b0, 24'hFFFFFF, 1'b1, 16'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].tau, vecs[i].valid, vecs[i].theta,
            vecs[i].phi, vecs[i].score, vecs[i].last);
      step();
      check_outs($sformatf("v%0d", i), vecs[i].exp_rdy, vecs[i].exp_buf,
                 vecs[i].exp_nm, vecs[i].exp_mc);
    end

    // Five qualifying, three failing at tau=1; best is score 900 (index 5).
    begin
      logic [15:0] scores [8];
      scores = '{16'd256, 16'd100, 16'd700, 16'd255, 16'd300, 16'd900, 16'd0, 16'd400};
      drive(1'b1, 8'd1, 1'b0, 12'h0, 12'h0, 16'd0, 1'b0);
      step();
      for (int k = 0; k < 8; k++) begin
        drive(1'b0, 8'd0, 1'b1, 12'(k), 12'(k + 256), scores[k], 1'(k == 7));
        step();
      end
      idle();
      check_outs("cnt_end", 1'b1, 24'h005105, 1'b0, mc(16'd5));
      step();
      step();
      check_outs("cnt_done", 1'b0, 24'h005105, 1'b0, mc(16'd5));
    end

    // Asynchronous reset during the strobe.
    drive(1'b1, 8'd1, 1'b0, 12'h0, 12'h0, 16'd0, 1'b0);
    step();
    drive(1'b0, 8'd0, 1'b1, 12'h055, 12'h066, 16'd600, 1'b1);
    step();
    idle();
    check("rpt_rdy_before_rst", 32'(o_best_angle_rdy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_outs("rst_in_rpt", 1'b0, 24'hFFFFFF, 1'b1, 16'd0);
    step();
    rst = 1'b1;
    // IDLE must ignore candidates, including one marked last.
    drive(1'b0, 8'd0, 1'b1, 12'h0FA, 12'h0FB, 16'd9000, 1'b1);
    step();
    idle();
    step();
    check_outs("idle_ignore", 1'b0, 24'hFFFFFF, 1'b1, 16'd0);
    // Fresh pass after reset; tau=0 lets a zero score qualify.
    drive(1'b1, 8'd0, 1'b0, 12'h0, 12'h0, 16'd0, 1'b0);
    step();
    drive(1'b0, 8'd0, 1'b1, 12'h0AB, 12'h0CD, 16'd0, 1'b1);
    step();
    idle();
    check_outs("post_rst_pass", 1'b1, 24'h0AB0CD, 1'b0, mc(16'd1));
    step();
    check("post_rst_rdy2", 32'(o_best_angle_rdy), 32'd1);
    step();
    check("post_rst_rdy3", 32'(o_best_angle_rdy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
